// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
// Shared definitions for the bit-serial adder/subtractor:
//   state_t    - controller states (IDLE, SHIFT, DONE)
//   cnt_width  - width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // The floor of 1 keeps the vector legal for degenerate widths.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Purely combinational one-bit full adder; the only arithmetic element of the
// bit-serial adder/subtractor.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first, built
// around a single full-adder cell. One result every WIDTH+1 cycles.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request pulse, sampled in IDLE or DONE
//   sub        in   0: a+b, 1: a-b (sampled with start)
//   a, b       in   operands (sampled with start)
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse when result/flags update
//   result     out  sum/difference of the last completed operation
//   carry_out  out  carry out of MSB (add) / NOT borrow (sub)
//   overflow   out  signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             load;
    logic             fa_s, fa_c;
    logic             cin_msb;

    full_adder_cell u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // On the last bit the running carry is the carry into the MSB position.
    assign cin_msb  = carry;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            // busy/done are decoded from the next state so they come straight
            // out of flops and line up with the state they describe.
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);

            if (load) begin
                // Subtraction is a + ~b + 1: invert b and seed the carry.
                opa    <= a;
                opb    <= sub ? ~b : b;
                carry  <= sub;
                cnt    <= '0;
                sum_sr <= '0;
            end else if (state == SHIFT) begin
                opa    <= {1'b0, opa[WIDTH-1:1]};
                opb    <= {1'b0, opb[WIDTH-1:1]};
                sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                carry  <= fa_c;
                cnt    <= cnt + 1'b1;
                if (last_bit) begin
                    // Publish only complete results; the final sum bit is
                    // merged in here since sum_sr has not shifted it yet.
                    result    <= {fa_s, sum_sr[WIDTH-1:1]};
                    carry_out <= fa_c;
                    overflow  <= cin_msb ^ fa_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;
    logic         carry_out, overflow;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done, starting from a negedge; start is dropped on
    // the first cycle. Returns cycles elapsed, busy cycles seen, and whether
    // busy and done were ever observed together.
    task automatic wait_done(output int cyc, output int nbusy, output bit ok, output bit both);
        cyc = 0; nbusy = 0; ok = 1'b0; both = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy && done) both = 1'b1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
        a = ta; b = tb_; sub = ts; start = 1'b1;
    endtask

    int  cyc, nbusy, ndone;
    bit  ok, both;

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy",   busy,      0);
        chk("reset_done",   done,      0);
        chk("reset_result", result,    0);
        chk("reset_co",     carry_out, 0);
        chk("reset_ov",     overflow,  0);

        // Table-driven operations, each started from IDLE.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_done(cyc, nbusy, ok, both);
            chk($sformatf("v%0d_done_seen", i), ok, 1);
            chk($sformatf("v%0d_latency", i), cyc, 9);
            chk($sformatf("v%0d_busy_cycles", i), nbusy, 8);
            chk($sformatf("v%0d_busy_done_excl", i), both, 0);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_carry_out", i), carry_out, vecs[i].co);
            chk($sformatf("v%0d_overflow", i), overflow, vecs[i].ov);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_result_hold", i), result, vecs[i].res);
        end

        // start during SHIFT (busy cycle 3) is ignored.
        @(negedge clk);
        issue(8'h3C, 8'h5A, 1'b0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ign_busy_c3", busy, 1);
        issue(8'h01, 8'h01, 1'b1);
        wait_done(cyc, nbusy, ok, both);
        chk("ign_done_seen", ok, 1);
        chk("ign_latency", cyc, 6);
        chk("ign_result", result, 8'h96);
        chk("ign_co", carry_out, 0);
        chk("ign_ov", overflow, 1);

        // Back-to-back: start held in the done cycle.
        issue(8'h05, 8'h07, 1'b1);
        wait_done(cyc, nbusy, ok, both);
        chk("b2b_done_seen", ok, 1);
        chk("b2b_done_to_done", cyc, 9);
        chk("b2b_busy_cycles", nbusy, 8);
        chk("b2b_result", result, 8'hFE);
        chk("b2b_co", carry_out, 0);
        chk("b2b_ov", overflow, 0);

        // Reset at busy cycle 4 aborts the operation.
        @(negedge clk);
        issue(8'h80, 8'h01, 1'b1);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_c4", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy",   busy,      0);
        chk("rst_mid_done",   done,      0);
        chk("rst_mid_result", result,    0);
        chk("rst_mid_co",     carry_out, 0);
        chk("rst_mid_ov",     overflow,  0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("rst_no_done_after_abort", ndone, 0);

        issue(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, nbusy, ok, both);
        chk("post_rst_done_seen", ok, 1);
        chk("post_rst_latency", cyc, 9);
        chk("post_rst_result", result, 8'h00);
        chk("post_rst_co", carry_out, 1);
        chk("post_rst_ov", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
